// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search engine.
// Optional early exit on equality is enabled by defining SAR_EARLY_EXIT_EN.
package sar_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_t;

    // First trial of a search: only the top bit of a w-bit operand set.
    function automatic logic [15:0] msb_mask(input int w);
        msb_mask = 16'h0001 << (w - 1);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator-facing handshake of the search engine: the trial operand goes out,
// the le/eq/gr flags come back, and start/result/status go to the requester.
interface sar_search_if #(parameter int WIDTH = 8);
    logic             start;
    logic             cmp_le;
    logic             cmp_eq;
    logic             cmp_gr;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, cmp_le, cmp_eq, cmp_gr,
        input  trial, busy, done, result, err
    );

    modport slave (
        input  start, cmp_le, cmp_eq, cmp_gr,
        output trial, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_cmp_flag_check.sv
// One-hot check of the magnitude comparator flags; bad is high whenever
// zero or more than one of le/eq/gr are asserted.
module cmp_flag_check (
    input  logic le,
    input  logic eq,
    input  logic gr,
    output logic bad
);

    // Exactly one flag set is the only legal comparator response.
    always_comb begin
        bad = 1'b1;
        case ({le, eq, gr})
            3'b100:  bad = 1'b0;
            3'b010:  bad = 1'b0;
            3'b001:  bad = 1'b0;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    sar_search_if.slave  bus
);

    localparam int               IDXW    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB     = WIDTH'(msb_mask(WIDTH));
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0]  IDX_ONE = IDXW'(1);
    localparam logic [IDXW-1:0]  IDX_0   = {IDXW{1'b0}};

    sar_state_t       state_r;
    logic [WIDTH-1:0] trial_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] result_r;
    logic [IDXW-1:0]  idx_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             err_acc_r;

    logic             bad_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] trial_next_s;
    logic             last_s;

    cmp_flag_check u_flag_check (
        .le  (bus.cmp_le),
        .eq  (bus.cmp_eq),
        .gr  (bus.cmp_gr),
        .bad (bad_s)
    );

    // Decision for the current trial; a malformed flag set is resolved by gr alone.
    always_comb begin
        acc_next_s   = acc_r;
        trial_next_s = ZERO_W;
        last_s       = 1'b0;
        if (bus.cmp_gr) begin
            acc_next_s = acc_r;
        end else begin
            acc_next_s = trial_r;
        end
        trial_next_s = acc_next_s | (ONE_W << (idx_r - IDX_ONE));
`ifdef SAR_EARLY_EXIT_EN
        if (idx_r == IDX_0) begin
            last_s = 1'b1;
        end else if (bus.cmp_eq && !bad_s) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`else
        if (idx_r == IDX_0) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`endif
    end

    // Search FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            trial_r   <= ZERO_W;
            acc_r     <= ZERO_W;
            result_r  <= ZERO_W;
            idx_r     <= IDX_TOP;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            err_acc_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (bus.start) begin
                        state_r   <= TEST;
                        trial_r   <= MSB;
                        acc_r     <= ZERO_W;
                        idx_r     <= IDX_TOP;
                        err_acc_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                TEST: begin
                    if (bad_s) begin
                        err_acc_r <= 1'b1;
                    end
                    if (last_s) begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= acc_next_s;
                        err_r    <= err_acc_r | bad_s;
                        trial_r  <= ZERO_W;
                        acc_r    <= acc_next_s;
                    end else begin
                        idx_r   <= idx_r - IDX_ONE;
                        trial_r <= trial_next_s;
                        acc_r   <= acc_next_s;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r   <= TEST;
                        trial_r   <= MSB;
                        acc_r     <= ZERO_W;
                        idx_r     <= IDX_TOP;
                        err_acc_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    trial_r <= ZERO_W;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trial  = trial_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.err    = err_r;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator between trial and target.
module tb_sar_search;

    logic       clk;
    logic       rst;
    logic [7:0] target;
    logic       ovr;
    logic [2:0] ovr_flags;
    int         n_vec;
    int         n_err;

`ifdef SAR_EARLY_EXIT_EN
    localparam int B2B_FIRST = 7;
    localparam int CYC_5A    = 8;
`else
    localparam int B2B_FIRST = 9;
    localparam int CYC_5A    = 9;
`endif

    sar_search_if #(.WIDTH(8)) bus ();

    sar_search #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truthful comparator unless a flag fault is being injected.
    always_comb begin
        if (ovr) begin
            {bus.cmp_le, bus.cmp_eq, bus.cmp_gr} = ovr_flags;
        end else begin
            bus.cmp_le = (bus.trial <  target);
            bus.cmp_eq = (bus.trial == target);
            bus.cmp_gr = (bus.trial >  target);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a search at a falling edge and follow it to its done pulse.
    task automatic do_search(input logic [7:0] tgt, input logic [7:0] exp_res,
                             input logic exp_err, input int exp_cyc,
                             input int fault_at, input string tag);
        int cyc;
        target    = tgt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        ovr = (cyc == fault_at);
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ovr = (cyc == fault_at);
        end
        ovr = 1'b0;
        chk({tag, "_done"}, {15'd0, bus.done}, 16'd1);
        if (exp_cyc != 0) chk({tag, "_latency"}, 16'(cyc), 16'(exp_cyc));
        chk({tag, "_result"}, {8'd0, bus.result}, {8'd0, exp_res});
        chk({tag, "_err"}, {15'd0, bus.err}, {15'd0, exp_err});
        chk({tag, "_busy_at_done"}, {15'd0, bus.busy}, 16'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {15'd0, bus.done}, 16'd0);
    endtask

    initial begin
        logic [7:0] exp_a5 [8];
        int cyc;
        int saw_done;
        exp_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        target    = 8'h00;
        ovr       = 1'b0;
        ovr_flags = 3'b110;

        repeat (2) @(negedge clk);
        chk("rst_trial",  {8'd0, bus.trial},  16'd0);
        chk("rst_result", {8'd0, bus.result}, 16'd0);
        chk("rst_busy",   {15'd0, bus.busy},  16'd0);
        chk("rst_done",   {15'd0, bus.done},  16'd0);
        chk("rst_err",    {15'd0, bus.err},   16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Target 0xA5: walk the full trial sequence.
        target    = 8'hA5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_trial%0d", i), {8'd0, bus.trial}, {8'd0, exp_a5[i]});
            chk($sformatf("a5_busy%0d", i), {15'd0, bus.busy}, 16'd1);
            chk($sformatf("a5_nodone%0d", i), {15'd0, bus.done}, 16'd0);
            @(negedge clk);
        end
        chk("a5_done",   {15'd0, bus.done},  16'd1);
        chk("a5_busy",   {15'd0, bus.busy},  16'd0);
        chk("a5_result", {8'd0, bus.result}, 16'h00A5);
        chk("a5_err",    {15'd0, bus.err},   16'd0);
        chk("a5_trial0", {8'd0, bus.trial},  16'd0);
        repeat (3) @(negedge clk);
        chk("a5_done_low", {15'd0, bus.done},  16'd0);
        chk("a5_held",     {8'd0, bus.result}, 16'h00A5);

        do_search(8'h00, 8'h00, 1'b0, 9, 0, "t00");
        do_search(8'hFF, 8'hFF, 1'b0, 9, 0, "tff");

        // Back-to-back: 0x3C with an ignored start mid-search, then 0x01 from DONE.
        target    = 8'h3C;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            bus.start = (cyc == 4);
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 5) begin
                chk("b2b_ignored_trial", {8'd0, bus.trial}, 16'h0038);
                chk("b2b_ignored_busy",  {15'd0, bus.busy}, 16'd1);
            end
        end
        chk("b2b1_done",    {15'd0, bus.done},  16'd1);
        chk("b2b1_latency", 16'(cyc),           16'(B2B_FIRST));
        chk("b2b1_result",  {8'd0, bus.result}, 16'h003C);
        target    = 8'h01;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b2_trial", {8'd0, bus.trial}, 16'h0080);
        chk("b2b2_busy",  {15'd0, bus.busy}, 16'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b2_gap",    16'(cyc),           16'd9);
        chk("b2b2_result", {8'd0, bus.result}, 16'h0001);
        @(negedge clk);

        // Flag fault (le=eq=1) on the 3rd TEST cycle, then a clean search.
        do_search(8'h5A, 8'h60, 1'b1, 9, 3, "fault");
        do_search(8'h5A, 8'h5A, 1'b0, CYC_5A, 0, "clean");

        // Reset in the 5th TEST cycle aborts with no done.
        target    = 8'h77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {15'd0, bus.busy}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_trial",  {8'd0, bus.trial},  16'd0);
        chk("mid_rst_busy",   {15'd0, bus.busy},  16'd0);
        chk("mid_rst_result", {8'd0, bus.result}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done++;
        end
        chk("mid_rst_no_done", 16'(saw_done), 16'd0);
        do_search(8'h77, 8'h77, 1'b0, 0, 0, "after_rst");

`ifdef SAR_EARLY_EXIT_EN
        do_search(8'h80, 8'h80, 1'b0, 2, 0, "early80");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search engine that sits on the opposite side of the 8-bit magnitude comparator.
- It drives the comparator's trial operand (in1) and consumes the comparator's le/eq/gr flags. The external target is wired to in2.
- After WIDTH bit-decisions it returns the target value, with a done pulse and a flag-protocol error indication.
- Used as the controller wrapped around the existing comparator in the datapath.

Parameters:
- WIDTH, 8, width of the trial operand and result, in bits (legal range 2..16).

Ports:
- clk      input   1      single system clock; all state changes on its rising edge
- rst      input   1      asynchronous, active-high reset
- start    input   1      request a new search; sampled in IDLE or DONE only
- cmp_le   input   1      comparator flag: trial < target
- cmp_eq   input   1      comparator flag: trial == target
- cmp_gr   input   1      comparator flag: trial > target
- trial    output  WIDTH  operand driven to comparator in1; registered
- busy     output  1      high while a search is in progress (TEST state)
- done     output  1      one-cycle pulse when the result is final
- result   output  WIDTH  search result; held until the next accepted start
- err      output  1      cmp flags were not one-hot during the last search; valid with done, held with result

Behaviour:
- Reset (async, any state): state=IDLE; trial=0, result=0, busy=0, done=0, err=0; internal acc=0, bit index=WIDTH-1.
- States:
  - IDLE: start=1 → TEST; trial=1<<(WIDTH-1), acc=0, idx=WIDTH-1, err_acc=0.
  - TEST: busy=1. Each edge samples the cmp flags for the current trial.
    - gr=1 → acc_next=acc; otherwise (le or eq) acc_next=trial.
    - If idx>0: idx-=1 and trial=acc_next | (1<<(idx-1)).
    - If idx==0: → DONE, result=acc_next, trial=0.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - start=1 → TEST (back-to-back search; same init as IDLE).
    - Otherwise → IDLE.
- Latency:
  - start accepted at edge E0; trial MSB is valid after E0.
  - Flags are sampled at E1..E_WIDTH.
  - done and result are valid in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after start.
- The comparator is combinational; the flags must settle within the same cycle the trial is driven.
- Flag check: in any TEST cycle, if (cmp_le+cmp_eq+cmp_gr)!=1 then err_acc sets (sticky for that search).
  - err is loaded from err_acc at DONE.
  - The decision in a bad cycle uses gr alone.
- start during TEST is ignored; no queuing.
- err and result keep their values through IDLE until the next search completes.
- Reset mid-search aborts the search; no done is produced.
- Result is the floor search: for a truthful comparator, result == target for every target in 0..2^WIDTH-1, including 0 (all trials gr) and all-ones (all trials kept).

Optional Feature:
- Macro SAR_EARLY_EXIT_EN.
- Defined: in TEST, if cmp_eq=1 and flags are one-hot, then result=trial and → DONE immediately. Latency becomes variable, 2..WIDTH+1 cycles.
- Undefined: eq is treated like le; latency is always WIDTH+1.
- Error checking is unchanged in both cases.

Decomposition:
- Package sar_pkg:
  - state enum {IDLE, TEST, DONE}
  - default WIDTH constant
  - localparam function for MSB mask
- One natural sub-module, cmp_flag_check: combinational one-hot check of {le, eq, gr} producing a bad flag. It is reusable for any block consuming the comparator.
- The comparator itself stays outside; the bench instantiates it between trial and the target.

Test Plan:
- Target 0xA5, start pulse → expected sequence:
  - trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5
  - busy for 8 cycles; done one cycle later with result=0xA5, err=0.
- Target 0x00 → all trials gr; result=0x00.
- Target 0xFF → all trials kept; result=0xFF.
- Back-to-back: target 0x3C, then start held in the DONE cycle with target 0x01.
  - Expect two done pulses 9 cycles apart, results 0x3C and 0x01.
  - A start pulse in the 4th TEST cycle is ignored.
- Force cmp_le=cmp_eq=1 on the 3rd TEST cycle of a 0x5A search → done with err=1; the next clean search returns err=0.
- Assert rst in the 5th TEST cycle → trial, busy and result go to 0 immediately with no done.
  - With SAR_EARLY_EXIT_EN, target 0x80 → done 2 cycles after start, result=0x80.
